// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the instruction fetch path
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        UPDATE,
        HALT
    } fetch_state_t;

    localparam logic [2:0]  PCSEL_IMM        = 3'd0;
    localparam logic [2:0]  PCSEL_ALU        = 3'd1;
    localparam logic [31:0] INST_BYTES       = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - next program counter target selection and alignment flag
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target = pc + INST_BYTES;
        if (br_taken) begin
            case (pc_sel)
                PCSEL_IMM: target = pc + imm;
                PCSEL_ALU: target = alu_result & 32'hFFFF_FFFE;
                default:   target = pc + INST_BYTES;
            endcase
        end
        // Bit 0 is only ever set on the PC+IMM path; JALR clears it above.
        misaligned = target[1] | target[0];
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - program counter owner and instruction fetch sequencer
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic [31:0] MEM_INST,
    output logic        INST_ENB,
    input  logic        CU_DONE,
    input  logic        BR_TAKEN,
    input  logic [2:0]  PC_MUX_SELECT,
    input  logic [31:0] IMM,
    input  logic [31:0] ALU_RESULT,
    output logic [31:0] PC_ADDR,
    output logic [31:0] PC_PLUS4,
    output logic        FAULT
);

    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

    fetch_state_t state, state_n;

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic [7:0]  ack_cnt;
    logic        cu_done_q;
    logic        br_q;
    logic [2:0]  sel_q;
    logic [31:0] imm_q;
    logic [31:0] alu_q;

    logic        cu_rise;
    logic        ld_inst;
    logic        ld_branch;
    logic        ld_pc;
    logic        set_fault;
    logic        cnt_inc;
    logic [31:0] target;
    logic        misaligned;

    assign cu_rise = CU_DONE & ~cu_done_q;

    next_pc_calc u_next_pc (
        .pc         (pc_q),
        .br_taken   (br_q),
        .pc_sel     (sel_q),
        .imm        (imm_q),
        .alu_result (alu_q),
        .target     (target),
        .misaligned (misaligned)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        MEM_REQ   = 1'b0;
        INST_ENB  = 1'b0;
        ld_inst   = 1'b0;
        ld_branch = 1'b0;
        ld_pc     = 1'b0;
        set_fault = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                MEM_REQ = 1'b1;
                // A response in the final allowed cycle still wins over the timeout.
                if (MEM_ACK) begin
                    ld_inst = 1'b1;
                    state_n = ISSUE;
                end else if (ack_cnt == ACK_LAST) begin
                    set_fault = 1'b1;
                    state_n   = HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ISSUE: begin
                INST_ENB = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (cu_rise) begin
                    ld_branch = 1'b1;
                    state_n   = UPDATE;
                end
            end
            UPDATE: begin
                if (misaligned) begin
                    set_fault = 1'b1;
                    state_n   = HALT;
                end else begin
                    ld_pc   = 1'b1;
                    state_n = FETCH;
                end
            end
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            fault_q   <= 1'b0;
            ack_cnt   <= '0;
            cu_done_q <= CU_DONE;
            br_q      <= 1'b0;
            sel_q     <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
        end else begin
            // The edge register follows CU_DONE in every state so stale levels never look like edges.
            cu_done_q <= CU_DONE;
            ack_cnt   <= cnt_inc ? ack_cnt + 8'd1 : 8'd0;
            if (ld_inst) begin
                inst_q <= MEM_RDATA;
            end
            if (ld_branch) begin
                br_q  <= BR_TAKEN;
                sel_q <= PC_MUX_SELECT;
                imm_q <= IMM;
                alu_q <= ALU_RESULT;
            end
            if (ld_pc) begin
                pc_q <= target;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign PC_ADDR  = pc_q;
    assign MEM_ADDR = pc_q;
    assign PC_PLUS4 = pc_q + INST_BYTES;
    assign MEM_INST = inst_q;
    assign FAULT    = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] MEM_ADDR;
    logic        MEM_REQ;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic [31:0] MEM_INST;
    logic        INST_ENB;
    logic        CU_DONE;
    logic        BR_TAKEN;
    logic [2:0]  PC_MUX_SELECT;
    logic [31:0] IMM;
    logic [31:0] ALU_RESULT;
    logic [31:0] PC_ADDR;
    logic [31:0] PC_PLUS4;
    logic        FAULT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    bit          halted;

    inst_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .ACK_TIMEOUT (16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_REQ       (MEM_REQ),
        .MEM_ACK       (MEM_ACK),
        .MEM_RDATA     (MEM_RDATA),
        .MEM_INST      (MEM_INST),
        .INST_ENB      (INST_ENB),
        .CU_DONE       (CU_DONE),
        .BR_TAKEN      (BR_TAKEN),
        .PC_MUX_SELECT (PC_MUX_SELECT),
        .IMM           (IMM),
        .ALU_RESULT    (ALU_RESULT),
        .PC_ADDR       (PC_ADDR),
        .PC_PLUS4      (PC_PLUS4),
        .FAULT         (FAULT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: jump targets from the architectural rules, alignment as "divisible by 4".
    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic br,
                                                 input logic [2:0] sel, input logic [31:0] imm,
                                                 input logic [31:0] alu);
        if (br && sel == 3'd0) return pc + imm;
        if (br && sel == 3'd1) return alu - (alu % 2);
        return pc + 32'd4;
    endfunction

    task automatic do_reset(input bit late_ack);
        RST       = 1'b1;
        MEM_ACK   = late_ack;
        MEM_RDATA = $urandom;
        CU_DONE   = 1'($urandom_range(0, 1));
        step();
        chk("rst_req", 32'(MEM_REQ), 32'd0);
        chk("rst_pc", PC_ADDR, 32'h0);
        chk("rst_fault", 32'(FAULT), 32'd0);
        chk("rst_enb", 32'(INST_ENB), 32'd0);
        chk("rst_inst", MEM_INST, 32'h0);
        RST = 1'b0;
        step();
        chk("idle_ack_ignored", MEM_INST, 32'h0);
        chk("restart_req", 32'(MEM_REQ), 32'd1);
        MEM_ACK = 1'b0;
        exp_pc  = 32'h0;
        halted  = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] word, input int ack_wait, input int cu_wait,
                            input bit cu_early, input logic br, input logic [2:0] sel,
                            input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] tgt;
        chk("fetch_req", 32'(MEM_REQ), 32'd1);
        chk("fetch_addr", MEM_ADDR, exp_pc);
        chk("pc_plus4", PC_PLUS4, exp_pc + 32'd4);
        for (int i = 0; i < ack_wait; i++) begin
            MEM_ACK = 1'b0;
            CU_DONE = 1'($urandom_range(0, 1));
            step();
            chk("req_held", 32'(MEM_REQ), 32'd1);
        end
        MEM_ACK   = 1'b1;
        MEM_RDATA = word;
        CU_DONE   = 1'b0;
        step();
        MEM_ACK   = 1'b0;
        MEM_RDATA = $urandom;
        chk("issue_enb", 32'(INST_ENB), 32'd1);
        chk("issue_req", 32'(MEM_REQ), 32'd0);
        chk("issue_inst", MEM_INST, word);
        if (cu_early) CU_DONE = 1'b1;
        step();
        chk("enb_one_cycle", 32'(INST_ENB), 32'd0);
        if (cu_early) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk("early_hold_pc", PC_ADDR, exp_pc);
                chk("early_hold_req", 32'(MEM_REQ), 32'd0);
            end
            CU_DONE = 1'b0;
            step();
            chk("early_low_pc", PC_ADDR, exp_pc);
        end else begin
            for (int i = 1; i < cu_wait; i++) step();
        end
        CU_DONE       = 1'b1;
        BR_TAKEN      = br;
        PC_MUX_SELECT = sel;
        IMM           = imm;
        ALU_RESULT    = alu;
        step();
        chk("wait_inst_stable", MEM_INST, word);
        chk("wait_pc_stable", PC_ADDR, exp_pc);
        CU_DONE       = 1'b0;
        BR_TAKEN      = 1'($urandom_range(0, 1));
        PC_MUX_SELECT = 3'($urandom_range(0, 7));
        IMM           = $urandom;
        ALU_RESULT    = $urandom;
        step();
        tgt = model_target(exp_pc, br, sel, imm, alu);
        if (tgt % 4 != 0) begin
            chk("misalign_fault", 32'(FAULT), 32'd1);
            chk("misalign_req", 32'(MEM_REQ), 32'd0);
            chk("misalign_pc", PC_ADDR, exp_pc);
            halted = 1'b1;
        end else begin
            exp_pc = tgt;
            chk("next_fault", 32'(FAULT), 32'd0);
            chk("next_req", 32'(MEM_REQ), 32'd1);
            chk("next_addr", MEM_ADDR, exp_pc);
        end
    endtask

    initial begin
        logic [2:0]  rsel;
        logic [31:0] rimm;
        logic [31:0] ralu;
        RST           = 1'b1;
        MEM_ACK       = 1'b0;
        MEM_RDATA     = '0;
        CU_DONE       = 1'b0;
        BR_TAKEN      = 1'b0;
        PC_MUX_SELECT = '0;
        IMM           = '0;
        ALU_RESULT    = '0;
        exp_pc        = '0;
        halted        = 1'b0;

        do_reset(1'b0);

        // Sequential fetches 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) do_instr($urandom, 0, 2, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Branch and jump targets.
        do_instr($urandom, 0, 2, 1'b0, 1'b1, 3'd0, 32'h0000_00F4, 32'h0);
        chk("reach_100", PC_ADDR, 32'h100);
        do_instr($urandom, 0, 2, 1'b0, 1'b1, 3'd0, 32'hFFFF_FFF0, 32'h0);
        chk("imm_back", MEM_ADDR, 32'hF0);
        do_instr($urandom, 1, 3, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0101);
        do_instr($urandom, 0, 1, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_2001);
        chk("jalr_target", MEM_ADDR, 32'h2000);
        do_instr($urandom, 0, 2, 1'b0, 1'b1, 3'd5, 32'h40, 32'h80);
        chk("other_sel_plus4", MEM_ADDR, 32'h2004);
        do_instr($urandom, 0, 2, 1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_0100);

        // Misaligned jump halts with the PC frozen.
        do_instr($urandom, 0, 2, 1'b0, 1'b1, 3'd0, 32'h0000_0102, 32'h0);
        for (int i = 0; i < 3; i++) begin
            MEM_ACK = 1'($urandom_range(0, 1));
            CU_DONE = ~CU_DONE;
            step();
            chk("halt_pc", PC_ADDR, 32'h100);
            chk("halt_req", 32'(MEM_REQ), 32'd0);
            chk("halt_enb", 32'(INST_ENB), 32'd0);
        end

        // Fetch timeout at the 16th cycle without a response.
        do_reset(1'b0);
        MEM_ACK = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("timeout_not_yet", 32'(FAULT), 32'd0);
        chk("timeout_req_held", 32'(MEM_REQ), 32'd1);
        step();
        chk("timeout_fault", 32'(FAULT), 32'd1);
        chk("timeout_req", 32'(MEM_REQ), 32'd0);

        // Response in cycle 15, then in the timeout cycle itself.
        do_reset(1'b1);
        do_instr(32'hCAFE_0015, 14, 2, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        do_instr(32'hCAFE_0016, 15, 2, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("ack_priority_fault", 32'(FAULT), 32'd0);

        // CU_DONE already high at ISSUE is not a completion.
        do_instr($urandom, 0, 2, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0);

        // 32-bit wrap from the top of the address space.
        do_instr($urandom, 0, 2, 1'b0, 1'b1, 3'd1, 32'h0, 32'hFFFF_FFFC);
        do_instr($urandom, 0, 2, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("wrap_zero", PC_ADDR, 32'h0);

        // Reset while a request is outstanding, with a late response.
        do_instr($urandom, 0, 2, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("pre_reset_req", 32'(MEM_REQ), 32'd1);
        do_reset(1'b1);

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 40; n++) begin
            rsel = ($urandom_range(0, 3) < 3) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
            rimm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ralu = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            do_instr($urandom, $urandom_range(0, 5), $urandom_range(1, 4),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rsel, rimm, ralu);
            if (halted) do_reset(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
